// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package regfile_mp_pkg;

    typedef logic bool_t;
    localparam bool_t TRUE  = 1'b1;
    localparam bool_t FALSE = 1'b0;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_width_t;

    // Register 0 is hard-wired and out-of-range addresses (non-power-of-two files) are dead.
    function automatic bool_t addr_live(input int unsigned addr, input int unsigned num_regs);
        return (addr != 0 && addr < num_regs) ? TRUE : FALSE;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, writeback retires it, flush clears all.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int NUM_ISSUE = 2,
    parameter int NUM_WRITE = 2,
    parameter int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [NUM_WRITE-1:0]              write_ena,
    input  logic [NUM_WRITE-1:0][ADDR_W-1:0]  write_addr,
    input  logic [NUM_ISSUE-1:0]              issue_ena,
    input  logic [NUM_ISSUE-1:0][ADDR_W-1:0]  issue_addr,
    output logic [NUM_REGS-1:0]               busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;

    // Clears are applied before sets so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (write_ena[w] && addr_live(32'(write_addr[w]), NUM_REGS)) begin
                busy_next[write_addr[w]] = 1'b0;
            end
        end
        for (int s = 0; s < NUM_ISSUE; s++) begin
            if (issue_ena[s] && addr_live(32'(issue_addr[s]), NUM_REGS)) begin
                busy_next[issue_addr[s]] = 1'b1;
            end
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with same-cycle write bypass, highest-port write priority and busy scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int NUM_READ  = 4,
    parameter int NUM_WRITE = 2,
    parameter int NUM_ISSUE = 2,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_READ-1:0]               read_ena,
    input  logic [NUM_READ-1:0][ADDR_W-1:0]   read_addr,
    output logic [NUM_READ-1:0][DATA_W-1:0]   read_data,
    output logic [NUM_READ-1:0]               read_ready,
    input  logic [NUM_WRITE-1:0]              write_ena,
    input  logic [NUM_WRITE-1:0][ADDR_W-1:0]  write_addr,
    input  logic [NUM_WRITE-1:0][DATA_W-1:0]  write_data,
    input  logic [NUM_ISSUE-1:0]              issue_ena,
    input  logic [NUM_ISSUE-1:0][ADDR_W-1:0]  issue_addr,
    input  logic                              flush,
    output logic [NUM_REGS-1:0]               busy_vec
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Ascending loop: the last non-blocking assignment, i.e. the highest write port, wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (write_ena[w] && addr_live(32'(write_addr[w]), NUM_REGS)) begin
                    mem[write_addr[w]] <= write_data[w];
                end
            end
        end
    end

    always_comb begin
        read_data  = '0;
        read_ready = '1;
        for (int i = 0; i < NUM_READ; i++) begin
            if (rst_n && read_ena[i] && addr_live(32'(read_addr[i]), NUM_REGS)) begin
                read_data[i]  = mem[read_addr[i]];
                read_ready[i] = ~busy_vec[read_addr[i]];
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (write_ena[w] && write_addr[w] == read_addr[i]) begin
                        read_data[i]  = write_data[w];
                        read_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_ISSUE (NUM_ISSUE),
        .NUM_WRITE (NUM_WRITE),
        .ADDR_W    (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .write_ena  (write_ena),
        .write_addr (write_addr),
        .issue_ena  (issue_ena),
        .issue_addr (issue_addr),
        .busy_vec   (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp: expectations are queued with the stimulus, drained at negedge.
module tb_regfile_mp;

    localparam int NR = 4;
    localparam int NW = 2;
    localparam int NI = 2;
    localparam int DW = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NR-1:0]          read_ena;
    logic [NR-1:0][AW-1:0]  read_addr;
    logic [NR-1:0][DW-1:0]  read_data;
    logic [NR-1:0]          read_ready;
    logic [NW-1:0]          write_ena;
    logic [NW-1:0][AW-1:0]  write_addr;
    logic [NW-1:0][DW-1:0]  write_data;
    logic [NI-1:0]          issue_ena;
    logic [NI-1:0][AW-1:0]  issue_addr;
    logic                   flush;
    logic [NREGS-1:0]       busy_vec;

    regfile_mp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_ena   (read_ena),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_ready (read_ready),
        .write_ena  (write_ena),
        .write_addr (write_addr),
        .write_data (write_data),
        .issue_ena  (issue_ena),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    typedef enum int {K_DATA, K_READY, K_BUSY} kind_e;
    typedef struct {
        kind_e       kind;
        int          port;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic exp_rd(input int port, input logic [31:0] data, input logic ready, input string tag);
        exp_q.push_back('{K_DATA,  port, data,          {tag, "_data"}});
        exp_q.push_back('{K_READY, port, {31'd0, ready}, {tag, "_ready"}});
    endtask

    task automatic exp_busy(input logic [31:0] v, input string tag);
        exp_q.push_back('{K_BUSY, 0, v, {tag, "_busy"}});
    endtask

    task automatic clear_in();
        read_ena   = '0;
        read_addr  = '0;
        write_ena  = '0;
        write_addr = '0;
        write_data = '0;
        issue_ena  = '0;
        issue_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic rd(input int port, input int addr);
        read_ena[port]  = 1'b1;
        read_addr[port] = AW'(addr);
    endtask

    task automatic wr(input int port, input int addr, input logic [31:0] data);
        write_ena[port]  = 1'b1;
        write_addr[port] = AW'(addr);
        write_data[port] = data;
    endtask

    task automatic iss(input int port, input int addr);
        issue_ena[port]  = 1'b1;
        issue_addr[port] = AW'(addr);
    endtask

    // Sample at negedge, then advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_DATA:  chk(e.tag, read_data[e.port], e.val);
                K_READY: chk(e.tag, {31'd0, read_ready[e.port]}, e.val);
                default: chk(e.tag, busy_vec, e.val);
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        rst_n = 1'b0;
        for (int p = 0; p < NR; p++) rd(p, p + 1);
        for (int p = 0; p < NR; p++) exp_rd(p, 32'h0, 1'b1, "in_reset");
        tick();
        tick();
        rst_n = 1'b1;

        for (int c = 0; c < NREGS / NR; c++) begin
            clear_in();
            for (int p = 0; p < NR; p++) begin
                rd(p, c * NR + p);
                exp_rd(p, 32'h0, 1'b1, $sformatf("rst_r%0d", c * NR + p));
            end
            exp_busy(32'h0, "rst");
            tick();
        end

        clear_in();
        wr(0, 5, 32'hDEADBEEF);
        rd(0, 5);
        exp_rd(0, 32'hDEADBEEF, 1'b1, "byp_r5");
        tick();
        clear_in();
        rd(0, 5);
        rd(3, 5);
        exp_rd(0, 32'hDEADBEEF, 1'b1, "arr_r5");
        exp_rd(3, 32'hDEADBEEF, 1'b1, "arr_r5_p3");
        tick();

        clear_in();
        wr(0, 7, 32'h1);
        wr(1, 7, 32'h2);
        rd(1, 7);
        exp_rd(1, 32'h2, 1'b1, "prio_byp_r7");
        tick();
        clear_in();
        rd(2, 7);
        exp_rd(2, 32'h2, 1'b1, "prio_arr_r7");
        tick();
        clear_in();
        wr(1, 0, 32'h55);
        rd(2, 0);
        exp_rd(2, 32'h0, 1'b1, "r0_byp");
        tick();
        clear_in();
        rd(2, 0);
        exp_rd(2, 32'h0, 1'b1, "r0_arr");
        tick();

        clear_in();
        iss(0, 9);
        rd(0, 9);
        exp_rd(0, 32'h0, 1'b1, "iss_same_cyc");
        exp_busy(32'h0, "iss_same_cyc");
        tick();
        clear_in();
        rd(0, 9);
        exp_rd(0, 32'h0, 1'b0, "pend_r9");
        exp_busy(32'h1 << 9, "pend_r9");
        tick();
        clear_in();
        wr(0, 9, 32'h77);
        rd(1, 9);
        exp_rd(1, 32'h77, 1'b1, "wb_byp_r9");
        exp_busy(32'h1 << 9, "wb_same_cyc");
        tick();
        clear_in();
        rd(1, 9);
        exp_rd(1, 32'h77, 1'b1, "wb_done_r9");
        exp_busy(32'h0, "wb_done");
        tick();
        clear_in();
        iss(1, 9);
        wr(1, 9, 32'h88);
        tick();
        clear_in();
        rd(0, 9);
        exp_rd(0, 32'h88, 1'b0, "set_wins_r9");
        exp_busy(32'h1 << 9, "set_wins");
        tick();

        clear_in();
        iss(0, 3);
        iss(1, 4);
        tick();
        clear_in();
        iss(0, 6);
        iss(1, 0);
        tick();
        clear_in();
        flush = 1'b1;
        iss(0, 8);
        wr(0, 3, 32'h9);
        exp_busy((32'h1 << 9) | (32'h1 << 3) | (32'h1 << 4) | (32'h1 << 6), "pre_flush");
        tick();
        clear_in();
        rd(0, 3);
        rd(1, 8);
        rd(2, 4);
        exp_rd(0, 32'h9, 1'b1, "flush_wr_r3");
        exp_rd(1, 32'h0, 1'b1, "flush_iss_r8");
        exp_rd(2, 32'h0, 1'b1, "flush_r4");
        exp_busy(32'h0, "post_flush");
        tick();

        clear_in();
        wr(0, 1, 32'hAB);
        iss(0, 2);
        tick();
        clear_in();
        rd(0, 1);
        rd(1, 2);
        exp_rd(0, 32'hAB, 1'b1, "pre_rst_r1");
        exp_rd(1, 32'h0, 1'b0, "pre_rst_r2");
        exp_busy(32'h1 << 2, "pre_rst");
        tick();
        clear_in();
        rst_n = 1'b0;
        wr(1, 1, 32'hCD);
        iss(1, 10);
        rd(0, 1);
        rd(3, 5);
        exp_rd(0, 32'h0, 1'b1, "rst_force_r1");
        exp_rd(3, 32'h0, 1'b1, "rst_force_r5");
        tick();
        clear_in();
        rst_n = 1'b1;
        rd(0, 1);
        rd(1, 5);
        rd(2, 10);
        exp_rd(0, 32'h0, 1'b1, "post_rst_r1");
        exp_rd(1, 32'h0, 1'b1, "post_rst_r5");
        exp_rd(2, 32'h0, 1'b1, "post_rst_r10");
        exp_busy(32'h0, "post_rst");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the dual-issue MIPS core, successor to the fixed 4-read/2-write register file. It adds same-cycle write-to-read bypass, deterministic write-port priority, and an integrated busy-bit scoreboard that lets the issue stage detect pending producers. It sits between decode/issue, which reads operands and marks destinations, and writeback, which commits results.

## Interface
- NUM_READ, 4, number of read ports
- NUM_WRITE, 2, number of write ports
- NUM_ISSUE, 2, number of destination-allocation (issue) ports
- DATA_W, 32, register width
- NUM_REGS, 32, register count; register 0 is hard-wired zero
- ADDR_W, $clog2(NUM_REGS), register address width

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- read_ena  in  NUM_READ  per-port read enable
- read_addr  in  NUM_READ×ADDR_W  read addresses
- read_data  out  NUM_READ×DATA_W  read data (combinational)
- read_ready  out  NUM_READ  operand valid: not pending, or bypassed this cycle
- write_ena  in  NUM_WRITE  writeback enable
- write_addr  in  NUM_WRITE×ADDR_W  writeback addresses
- write_data  in  NUM_WRITE×DATA_W  writeback data
- issue_ena  in  NUM_ISSUE  mark destination pending
- issue_addr  in  NUM_ISSUE×ADDR_W  destination addresses
- flush  in  1  clear every busy bit (pipeline squash)
- busy_vec  out  NUM_REGS  current scoreboard state (registered)

## Operation
- Read port i, combinational:
  - read_ena[i]=0: data 0, ready 1.
  - Address 0: data 0, ready 1.
  - An enabled write port targets the same nonzero address this cycle: data = that port's write_data, ready 1. If several ports match, the highest index wins.
  - Otherwise: data = array entry, ready = ~busy[addr].
  - rst_n=0: all read_data forced to 0, all read_ready to 1.
- Write, registered on the clock edge:
  - Enabled ports with nonzero address update the array.
  - If two ports target the same address, the highest index wins.
  - Writes to register 0 are discarded.
  - Writes are performed even when flush=1.
- Scoreboard, registered:
  - A write to r clears busy[r].
  - An issue to r sets busy[r].
  - When set and clear hit the same register in the same cycle, set wins (a new producer supersedes the retiring one).
  - Issue to register 0 is ignored; busy[0] is always 0.
  - flush=1: next busy = all 0, and same-cycle issues are ignored.
- Reset (rst_n=0 at an edge): all registers are set to 0 and busy_vec to 0; writes, issues and flush in that cycle are ignored. A reset asserted mid-operation discards pending writes.
- Arithmetic: no width conversion. Addresses at or above NUM_REGS (non-power-of-two NUM_REGS) are ignored for both write and issue, and read as 0 with ready 1.

## Timing
- Read latency is 0 cycles: a write is visible in the same cycle through the bypass, and from the array on following cycles.
- An issue at edge N sets busy, which is visible from cycle N+1.
- A write at cycle N clears busy at edge N+1, and read_ready is already 1 during cycle N through the bypass.
- busy_vec is a direct flop output, with no combinational path from any input.
- There is no back-pressure: every port is accepted every cycle.

## Structure
- Shared definitions belong in the common defines/package: the bool type, true/false constants, and the REG_ADDR/REG_WIDTH typedefs, generalised via ADDR_W/DATA_W.
- Sub-module regfile_scoreboard (NUM_REGS, NUM_ISSUE, NUM_WRITE) holds the busy-bit flops plus the set/clear/flush/reset logic.
- The top level contains the storage array, the write priority logic and the read bypass muxes.

## Test plan
- Reset, then read all 32 addresses on 4 ports: every read_data 0, read_ready 1, busy_vec 0.
- Write r5=0xDEADBEEF on port 0 while reading r5 in the same cycle: read_data 0xDEADBEEF (bypass). The next cycle reads 0xDEADBEEF from the array.
- Both write ports target r7 with 0x1 on port 0 and 0x2 on port 1: the bypass returns 0x2 and the next cycle reads 0x2. Writing 0x55 to r0 then reads back 0, ready 1.
- Scoreboard sequence:
  - Issue r9, then read r9: ready 0, busy_vec[9]=1.
  - Write r9=0x77: same-cycle ready 1 and data 0x77; busy_vec[9]=0 the next cycle.
  - Issue r9 and write r9 in the same cycle: busy_vec[9]=1 the next cycle.
- Flush with busy r3, r4, r6 and a simultaneous issue r8: busy_vec=0 the next cycle. A same-cycle write r3=0x9 still lands.
- Mid-operation reset: r1=0xAB, issue r2, then assert rst_n=0 for one edge together with a write r1=0xCD. Afterwards r1 reads 0 and busy_vec=0.
